i2c_cmd_sequencer: RTL and testbench

Avalon-MM slave I2C master that runs a single-register write or read transaction on an open-drain bus.
Software loads the device address, register address and data, then pulses start.
The block drives the bus and exports busy; busy feeds the existing i2c_busy PIO input for polling.
Sits on the Nios system bus beside the PIOs, one instance per I2C bus.

---
 rtl/i2c_seq_pkg.sv | 25 ++
 rtl/i2c_tick_gen.sv | 29 ++
 rtl/i2c_cmd_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared FSM state type, register map offsets and STATUS bit positions
// for the I2C command sequencer.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TX_BYTE,
        RX_ACK,
        RSTART,
        RX_BYTE,
        TX_ACK,
        STOP
    } state_t;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_DEV_REG = 2'd2;
    localparam logic [1:0] REG_DATA    = 2'd3;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_NACK = 1;
    localparam int unsigned STAT_DONE = 2;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator: counts 0..CLK_DIV-1 and ticks on wrap.
// Held at 0 while disabled; freezes while hold is high.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic hold,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt;

    assign tick = enable && !hold && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Avalon-MM I2C master running one single-register write or read transaction.
// Optional macro I2C_CLK_STRETCH_EN lets slaves stretch SCL during ph1/ph2.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in,
    input  logic        scl_in,
    output logic        busy
);

    state_t      state, state_next;
    logic [1:0]  phase;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic [7:0]  shift;
    logic [6:0]  dev;
    logic [7:0]  reg_addr;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;
    logic        rnw;
    logic        nack;
    logic        done;
    logic        tick;
    logic        hold;
    logic        scl_d, sda_d;
    logic [2:0]  status;

    logic wr_en, rd_en, idle, start_go, bit_end, sample;
    logic unused_wd;

    assign wr_en    = chipselect && write;
    assign rd_en    = chipselect && read;
    assign idle     = (state == IDLE);
    assign busy     = !idle;
    assign start_go = wr_en && (address == REG_CTRL) && writedata[0] && idle;
    assign bit_end  = tick && (phase == 2'd3);
    assign sample   = tick && (phase == 2'd2);
    assign unused_wd = ^writedata[31:16];

`ifdef I2C_CLK_STRETCH_EN
    // Only hold once the master itself has let go of SCL.
    assign hold = ((phase == 2'd1) || (phase == 2'd2)) && !scl_in && !scl_oe;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold = 1'b0;
`endif

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (reset_n),
        .enable (busy),
        .hold   (hold),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_go) state_next = START;
            START:   if (bit_end) state_next = TX_BYTE;
            RSTART:  if (bit_end) state_next = TX_BYTE;
            TX_BYTE: if (bit_end && bit_cnt == 3'd0) state_next = RX_ACK;
            RX_ACK: begin
                if (bit_end) begin
                    if (nack) begin
                        state_next = STOP;
                    end else begin
                        case (byte_idx)
                            2'd0:    state_next = TX_BYTE;
                            2'd1:    state_next = rnw ? RSTART : TX_BYTE;
                            default: state_next = rnw ? RX_BYTE : STOP;
                        endcase
                    end
                end
            end
            RX_BYTE: if (bit_end && bit_cnt == 3'd0) state_next = TX_ACK;
            TX_ACK:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus levels per phase; SDA only moves while SCL is low except for START/STOP.
    always_comb begin
        scl_d = 1'b0;
        sda_d = 1'b0;
        case (state)
            START: begin
                scl_d = (phase == 2'd3);
                sda_d = phase[1];
            end
            RSTART: begin
                scl_d = (phase == 2'd0) || (phase == 2'd3);
                sda_d = phase[1];
            end
            TX_BYTE: begin
                scl_d = (phase == 2'd0) || (phase == 2'd3);
                sda_d = !shift[7];
            end
            RX_ACK, RX_BYTE, TX_ACK: begin
                scl_d = (phase == 2'd0) || (phase == 2'd3);
            end
            STOP: begin
                scl_d = (phase == 2'd0);
                sda_d = !phase[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_oe <= 1'b0;
            sda_oe <= 1'b0;
        end else begin
            scl_oe <= scl_d;
            sda_oe <= sda_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            dev      <= '0;
            reg_addr <= '0;
            tx_data  <= '0;
            rx_data  <= '0;
            rnw      <= 1'b0;
            nack     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (wr_en && idle) begin
                case (address)
                    REG_DEV_REG: begin
                        dev      <= writedata[6:0];
                        reg_addr <= writedata[15:8];
                    end
                    REG_DATA: tx_data <= writedata[7:0];
                    default: ;
                endcase
            end
            if (start_go) begin
                rnw      <= writedata[1];
                nack     <= 1'b0;
                done     <= 1'b0;
                byte_idx <= '0;
                bit_cnt  <= 3'd7;
                shift    <= {dev, 1'b0};
            end
            if (idle)      phase <= '0;
            else if (tick) phase <= phase + 2'd1;
            if (sample) begin
                if (state == RX_ACK && sda_in) nack <= 1'b1;
                if (state == RX_BYTE) shift <= {shift[6:0], sda_in};
            end
            // bit_cnt wraps 0 -> 7 at each byte end, ready for the next byte.
            if (bit_end) begin
                case (state)
                    TX_BYTE: begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                    RX_BYTE: bit_cnt <= bit_cnt - 3'd1;
                    RX_ACK: begin
                        if (state_next == TX_BYTE) begin
                            shift    <= (byte_idx == 2'd0) ? reg_addr : tx_data;
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                    RSTART: begin
                        shift    <= {dev, 1'b1};
                        byte_idx <= 2'd2;
                    end
                    TX_ACK: rx_data <= shift;
                    STOP:   done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_NACK] = nack;
        status[STAT_DONE] = done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (address)
                REG_STATUS:  readdata <= {29'd0, status};
                REG_DEV_REG: readdata <= {16'd0, reg_addr, 1'b0, dev};
                REG_DATA:    readdata <= {24'd0, rx_data};
                default:     readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench: Avalon register access, I2C slave/bus decoder model,
// write/read/NACK/busy-protection/reset checks; stretch test with I2C_CLK_STRETCH_EN.
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        scl_oe, sda_oe, sda_in, scl_in, busy;

    logic slave_sda = 1'b0;
    logic slave_scl = 1'b0;
    logic scl_line, sda_line;

    assign scl_line = !(scl_oe || slave_scl);
    assign sda_line = !(sda_oe || slave_sda);
    assign sda_in   = sda_line;
    assign scl_in   = scl_line;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in),
        .scl_in     (scl_in),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus decoder / slave model. Events: 0x100 START, 0x101 repeated START,
    // 0x102 STOP, 0x200|bit for the ninth (ACK) bit, plain values for bytes.
    int         ev[$];
    int         exp_ev[$];
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitcnt = 0;
    int         byte_no = 0;
    logic [7:0] shreg = '0;
    logic       in_frame = 1'b0;
    logic       slave_tx = 1'b0;
    logic       addr_r = 1'b0;
    logic       ack_addr = 1'b1;
    logic [7:0] rd_byte = '0;
    int         busy_clks = 0;
    int         busy_rises = 0;
    logic       prev_busy = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    logic       stretch_en = 1'b0;
    int         stretch_left = 0;
`endif

    always @(negedge clk) begin : monitor
        logic s, d;
        s = scl_line;
        d = sda_line;
        if (prev_scl && s && prev_sda && !d) begin
            ev.push_back(in_frame ? 32'h101 : 32'h100);
            in_frame = 1'b1;
            bitcnt = 0;
            byte_no = 0;
            slave_tx = 1'b0;
        end else if (prev_scl && s && !prev_sda && d) begin
            ev.push_back(32'h102);
            in_frame = 1'b0;
            slave_tx = 1'b0;
            slave_sda = 1'b0;
        end
        if (!prev_scl && s) begin
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], d};
                bitcnt++;
                if (bitcnt == 8) begin
                    ev.push_back(int'(shreg));
                    if (byte_no == 0) addr_r = shreg[0];
                end
            end else begin
                ev.push_back(d ? 32'h201 : 32'h200);
                bitcnt = 9;
            end
        end
        if (prev_scl && !s) begin
            if (bitcnt == 8) begin
                slave_sda = slave_tx ? 1'b0 : ((byte_no == 0) ? ack_addr : 1'b1);
            end else if (bitcnt == 9) begin
                slave_sda = 1'b0;
                bitcnt = 0;
                byte_no++;
                slave_tx = (byte_no == 1) && addr_r && ack_addr;
                if (slave_tx) slave_sda = !rd_byte[7];
            end else if (slave_tx && bitcnt > 0) begin
                slave_sda = !rd_byte[7 - bitcnt];
            end
`ifdef I2C_CLK_STRETCH_EN
            if (stretch_en && byte_no == 1 && bitcnt == 4) begin
                stretch_en = 1'b0;
                stretch_left = 50;
                slave_scl = 1'b1;
            end
`endif
        end
`ifdef I2C_CLK_STRETCH_EN
        if (slave_scl && !scl_oe) begin
            stretch_left--;
            if (stretch_left <= 0) slave_scl = 1'b0;
        end
`endif
        prev_scl = s;
        prev_sda = d;
    end

    always @(negedge clk) begin
        if (busy) busy_clks++;
        if (busy && !prev_busy) busy_rises++;
        prev_busy = busy;
    end

    task automatic clear_mon();
        @(posedge clk);
        ev.delete();
        in_frame = 1'b0;
        bitcnt = 0;
        byte_no = 0;
        slave_tx = 1'b0;
        slave_sda = 1'b0;
        busy_clks = 0;
        busy_rises = 0;
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_events(input string tag);
        check({tag, "_nev"}, ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < ev.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), ev[i], exp_ev[i]);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_readdata", readdata, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        av_read(REG_STATUS, r);
        check("rst_status", r, 0);

        // Register write transaction
        av_write(REG_DEV_REG, 32'h0000_051A);
        av_write(REG_DATA, 32'h0000_00A5);
        av_read(REG_DEV_REG, r);
        check("devreg_rb", r, 32'h0000_051A);
        clear_mon();
        av_write(REG_CTRL, 32'h1);
        check("wr_busy_rise", busy, 1);
        wait_idle("wr", 2000);
        exp_ev = '{32'h100, 32'h34, 32'h200, 32'h05, 32'h200, 32'hA5, 32'h200, 32'h102};
        check_events("wr");
        av_read(REG_STATUS, r);
        check("wr_status", r, 32'h4);
        check("wr_busy_clks", (busy_clks >= 463 && busy_clks <= 465) ? 464 : busy_clks, 464);
        check("wr_busy_rises", busy_rises, 1);

        // Writes and start attempts while busy are ignored
        clear_mon();
        av_write(REG_CTRL, 32'h1);
        repeat (100) @(negedge clk);
        av_write(REG_DATA, 32'h0000_00FF);
        av_write(REG_DEV_REG, 32'h0000_0000);
        av_write(REG_CTRL, 32'h1);
        av_read(REG_STATUS, r);
        check("mid_status", r, 32'h1);
        wait_idle("prot", 2000);
        check_events("prot");
        repeat (200) @(negedge clk);
        check("prot_busy_after", busy, 0);
        check("prot_busy_rises", busy_rises, 1);
        av_read(REG_DEV_REG, r);
        check("prot_devreg", r, 32'h0000_051A);

        // Register read transaction
        av_write(REG_DEV_REG, 32'h0000_1050);
        rd_byte = 8'h3C;
        clear_mon();
        av_write(REG_CTRL, 32'h3);
        wait_idle("rd", 3000);
        exp_ev = '{32'h100, 32'hA0, 32'h200, 32'h10, 32'h200, 32'h101,
                   32'hA1, 32'h200, 32'h3C, 32'h201, 32'h102};
        check_events("rd");
        av_read(REG_DATA, r);
        check("rd_data", r, 32'h3C);
        av_read(REG_STATUS, r);
        check("rd_status", r, 32'h4);

        // Address NACK aborts straight to STOP
        av_write(REG_DEV_REG, 32'h0000_051A);
        ack_addr = 1'b0;
        clear_mon();
        av_write(REG_CTRL, 32'h1);
        wait_idle("nack", 2000);
        exp_ev = '{32'h100, 32'h34, 32'h201, 32'h102};
        check_events("nack");
        av_read(REG_STATUS, r);
        check("nack_status", r, 32'h6);
        av_read(REG_DATA, r);
        check("nack_data_kept", r, 32'h3C);
        ack_addr = 1'b1;

`ifdef I2C_CLK_STRETCH_EN
        clear_mon();
        stretch_en = 1'b1;
        av_write(REG_CTRL, 32'h1);
        wait_idle("str", 3000);
        exp_ev = '{32'h100, 32'h34, 32'h200, 32'h05, 32'h200, 32'hA5, 32'h200, 32'h102};
        check_events("str");
        check("str_busy_clks", (busy_clks >= 512 && busy_clks <= 516) ? 514 : busy_clks, 514);
`endif

        // Asynchronous reset in the middle of a transaction
        clear_mon();
        av_write(REG_CTRL, 32'h1);
        repeat (150) @(negedge clk);
        av_read(REG_STATUS, r);
        check("pre_rst_status", r, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_scl_oe", scl_oe, 0);
        check("arst_sda_oe", sda_oe, 0);
        check("arst_busy", busy, 0);
        check("arst_readdata", readdata, 0);
        @(negedge clk);
        reset_n = 1'b1;
        av_read(REG_STATUS, r);
        check("arst_status", r, 0);
        av_read(REG_DEV_REG, r);
        check("arst_devreg", r, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
